// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - shared defaults, FSM states and pattern bound helpers
package popcount_pkg;

  localparam int N_DEF  = 7;
  localparam int CW_DEF = 3;
  localparam int IW_DEF = 6;

  typedef enum logic {IDLE, RUN} state_t;

  // Smallest N-bit vector with k bits set: ones packed at the bottom.
  function automatic logic [N_DEF-1:0] first_pat(input logic [CW_DEF-1:0] k);
    logic [N_DEF:0] ext;
    ext = ({{N_DEF{1'b0}}, 1'b1} << k) - {{N_DEF{1'b0}}, 1'b1};
    return ext[N_DEF-1:0];
  endfunction

  // Largest N-bit vector with k bits set: ones packed at the top.
  function automatic logic [N_DEF-1:0] last_pat(input logic [CW_DEF-1:0] k);
    return first_pat(k) << (N_DEF - int'(k));
  endfunction

endpackage

// File: rtl/comb_next.sv
// rtl/comb_next.sv - combinational step to the next larger vector with the same ones-count
module comb_next #(
  parameter int N = 7
) (
  input  logic [N-1:0] v,
  output logic [N-1:0] v_next
);

  localparam int SW = $clog2(N + 1);
  localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

  logic [SW-1:0] ctz;
  logic [N:0]    t;
  logic [N:0]    t_inc;
  logic [N:0]    low;

  always_comb begin
    ctz = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) ctz = SW'(i);
    end
    // t fills the trailing zeros; t+1 moves the lowest ones-run up by one place.
    t     = {1'b0, v} | ({1'b0, v} - ONE);
    t_inc = t + ONE;
    low   = ((~t & t_inc) - ONE) >> (ctz + SW'(1));
  end

  assign v_next = t_inc[N-1:0] | low[N-1:0];

endmodule

// File: rtl/popcount_pattern_gen.sv
// rtl/popcount_pattern_gen.sv - enumerates all N-bit vectors with k ones over a valid/ready stream
module popcount_pattern_gen
  import popcount_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] k,
  input  logic          abort,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  pattern,
  output logic [IW-1:0] idx,
  output logic          last,
  output logic          done,
  output logic          err
);

  state_t        state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [N-1:0]  pattern_d, pat_next;
  logic [IW-1:0] idx_d;
  logic          last_d, busy_d, valid_d, done_d, err_d;

  comb_next #(.N(N)) u_comb_next (
    .v      (pattern),
    .v_next (pat_next)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    pattern_d = pattern;
    idx_d     = idx;
    last_d    = last;
    busy_d    = busy;
    valid_d   = out_valid;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (int'(k) > N) begin
            err_d = 1'b1;
          end else begin
            k_d       = k;
            pattern_d = first_pat(k);
            idx_d     = '0;
            last_d    = (k == '0) || (int'(k) == N);
            busy_d    = 1'b1;
            valid_d   = 1'b1;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        // Abort takes priority over a transfer in the same cycle.
        if (abort) begin
          busy_d  = 1'b0;
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (out_ready) begin
          if (last) begin
            busy_d  = 1'b0;
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            pattern_d = pat_next;
            idx_d     = idx + IW'(1);
            last_d    = (pat_next == last_pat(k_q));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      pattern   <= '0;
      idx       <= '0;
      last      <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      pattern   <= pattern_d;
      idx       <= idx_d;
      last      <= last_d;
      busy      <= busy_d;
      out_valid <= valid_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_popcount_pattern_gen.sv
// tb/tb_popcount_pattern_gen.sv - randomized self-checking bench with a cycle-level reference model
module tb_popcount_pattern_gen;

  localparam int N  = 7;
  localparam int CW = 3;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] k = '0;
  logic          busy, out_valid, last, done, err;
  logic [N-1:0]  pattern;
  logic [IW-1:0] idx;

  popcount_pattern_gen #(.N(N), .CW(CW), .IW(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .k         (k),
    .abort     (abort),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pattern   (pattern),
    .idx       (idx),
    .last      (last),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef int iq_t[$];

  int  tests = 0;
  int  fails = 0;
  int  dut_xfers = 0;
  iq_t obs;

  // Reference: every N-bit value with kk ones, in ascending order.
  function automatic iq_t build(input int kk);
    iq_t q;
    for (int v = 0; v < (1 << N); v++)
      if ($countones(v) == kk) q.push_back(v);
    return q;
  endfunction

  function automatic int at(input iq_t q, input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-level model: what the stream must show, updated from the inputs of each cycle.
  bit  m_run = 0;
  int  m_done = 0;
  iq_t m_exp;
  int  m_ptr = 0;
  int  h_pat = 0, h_idx = 0, h_last = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_pattern", pattern, 0);
      chk("rst_done", done, 0);
      m_run = 0; m_done = 0; h_pat = 0; h_idx = 0; h_last = 0;
    end else begin
      chk("busy", busy, m_run);
      chk("out_valid", out_valid, m_run);
      chk("done", done, m_done);
      chk("err", err, 0);
      if (m_run) begin
        chk("pattern", pattern, m_exp[m_ptr]);
        chk("idx", idx, m_ptr);
        chk("last", last, m_ptr == m_exp.size() - 1);
      end else begin
        chk("hold_pattern", pattern, h_pat);
        chk("hold_idx", idx, h_idx);
        chk("hold_last", last, h_last);
      end
      if (out_valid && out_ready && !abort) begin
        dut_xfers++;
        obs.push_back(int'(pattern));
      end
      m_done = 0;
      if (!m_run) begin
        if (start) begin
          m_exp = build(int'(k));
          m_ptr = 0;
          m_run = 1;
        end
      end else if (abort || out_ready) begin
        h_pat  = m_exp[m_ptr];
        h_idx  = m_ptr;
        h_last = (m_ptr == m_exp.size() - 1);
        if (abort) m_run = 0;
        else if (h_last != 0) begin
          m_run  = 0;
          m_done = 1;
        end else m_ptr++;
      end
    end
  end

  // Entered and left at posedge+1; returns the number of DUT transfers seen.
  task automatic run(input int kk, input bit rnd, input int inj_cyc, input bit inj_last,
                     input int abort_idx, output int n);
    int cyc;
    k = kk[CW-1:0];
    start = 1'b1;
    abort = 1'b0;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    dut_xfers = 0;
    obs.delete();
    cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == inj_cyc) || (inj_last && out_valid && last);
      if (start) k = 3'd5;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      abort = (abort_idx >= 0) && out_valid && (int'(idx) == abort_idx);
      if (!busy) break;
      if (cyc > 400) begin
        chk("run_timeout", cyc, 0);
        break;
      end
    end
    n = dut_xfers;
  endtask

  int  n;
  iq_t q;
  iq_t s;
  int  cnt;
  int  expc[8] = '{1, 7, 21, 35, 35, 21, 7, 1};

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_last", last, 0);
    chk("reset_idx", idx, 0);
    chk("reset_err", err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    q = build(3);
    chk("model_k3_size", q.size(), 35);
    chk("model_k3_first", at(q, 0), 7);
    chk("model_k3_second", at(q, 1), 11);
    chk("model_k3_final", at(q, 34), 112);
    q = build(2);
    chk("model_k2_size", q.size(), 21);

    run(3, 1'b0, -1, 1'b0, -1, n);
    chk("k3_count", n, 35);
    chk("k3_pat0", at(obs, 0), 7'b0000111);
    chk("k3_pat1", at(obs, 1), 7'b0001011);
    chk("k3_pat2", at(obs, 2), 7'b0001101);
    chk("k3_pat34", at(obs, 34), 7'b1110000);
    cnt = 0;
    foreach (obs[i]) if ($countones(obs[i]) != 3) cnt++;
    chk("k3_ones", cnt, 0);
    s = obs;
    s.sort();
    cnt = 0;
    for (int i = 1; i < s.size(); i++) if (s[i] == s[i-1]) cnt++;
    chk("k3_distinct", cnt, 0);

    run(0, 1'b0, -1, 1'b0, -1, n);
    chk("k0_count", n, 1);
    chk("k0_pat", at(obs, 0), 0);
    run(7, 1'b0, -1, 1'b0, -1, n);
    chk("k7_count", n, 1);
    chk("k7_pat", at(obs, 0), 7'b1111111);

    run(2, 1'b1, -1, 1'b0, -1, n);
    chk("k2_stall_count", n, 21);
    q = build(2);
    cnt = 0;
    for (int i = 0; i < 21; i++) if (at(obs, i) != q[i]) cnt++;
    chk("k2_stall_order", cnt, 0);

    run(1, 1'b0, 3, 1'b1, -1, n);
    chk("k1_ignore_start_count", n, 7);
    run(5, 1'b0, -1, 1'b0, -1, n);
    chk("k5_count", n, 21);

    run(4, 1'b0, -1, 1'b0, 10, n);
    chk("abort_count", n, 10);
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_no_done", done, 0);
    @(posedge clk); #1;
    chk("abort_no_done_late", done, 0);

    k = 3'd3;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_pattern", pattern, 0);
    chk("async_rst_idx", idx, 0);
    chk("async_rst_last", last, 0);
    chk("async_rst_done", done, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run(6, 1'b0, -1, 1'b0, -1, n);
    chk("post_reset_k6_count", n, 7);

    for (int kk = 0; kk < 8; kk++) begin
      run(kk, 1'b0, -1, 1'b0, -1, n);
      chk($sformatf("sweep_k%0d_count", kk), n, expc[kk]);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
